vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_timing_gen_if.sv | 55 +++++
 rtl/vga_axis_counter.sv | 89 ++++++++
 rtl/vga_timing_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Purpose:
//   Shared definitions for the 640x480 @ 60 Hz raster timing generator.
//   Holds the default timing constants, the derived line/frame totals, the
//   coordinate type used on every scan-coordinate bus, and a helper that
//   tells whether a total fits the coordinate width.
//
// Contents:
//   coord_t           10-bit scan coordinate (DrawX / DrawY)
//   DEF_H_* / DEF_V_* default horizontal / vertical region lengths
//   H_TOTAL / V_TOTAL clocks per line / lines per frame at the defaults
//   fits_coord()      1 when a total can be counted by a coord_t (0..total-1)
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   // Horizontal regions, in pixel clocks.
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;

   // Vertical regions, in lines.
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   // A total is countable when its last value (total-1) is representable and
   // the axis has at least two positions.
   function automatic bit fits_coord(input int total);
      return (total >= 2) && (total <= (1 << COORD_W));
   endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//
// Purpose:
//   Raster timing bus from the timing generator to the sprite/palette
//   pipelines and the VGA pins. There is no handshake: the producer presents
//   a new, fully registered sample on every vga_clk edge and consumers must
//   accept it in that cycle (valid is implicitly always 1, ready is not
//   modelled).
//
// Signals:
//   DrawX        current horizontal count, 0..H_TOTAL-1
//   DrawY        current vertical count,   0..V_TOTAL-1
//   hs           horizontal sync, active low
//   vs           vertical sync, active low
//   blank        1 = visible pixel, 0 = blanking
//   frame_start  high while (DrawX,DrawY) = (0,0)
//   line_start   high while DrawX = 0
//
// Modports:
//   master  timing generator (drives everything)
//   slave   consumer (samples everything)
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   coord_t DrawX;
   coord_t DrawY;
   logic   hs;
   logic   vs;
   logic   blank;
   logic   frame_start;
   logic   line_start;

   modport master (
      output DrawX,
      output DrawY,
      output hs,
      output vs,
      output blank,
      output frame_start,
      output line_start
   );

   modport slave (
      input DrawX,
      input DrawY,
      input hs,
      input vs,
      input blank,
      input frame_start,
      input line_start
   );

endinterface : vga_timing_gen_if

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//
// Purpose:
//   One raster axis (horizontal or vertical). Counts 0..TOTAL-1, advancing
//   only when i_advance is high, and decodes the sync region. The sync
//   qualifier is registered from the next-state count so it lines up with
//   o_count in the same cycle.
//
// Parameters:
//   VISIBLE, FRONT, SYNC, BACK  region lengths in counts; TOTAL is their sum
//
// Ports:
//   i_clk           clock
//   i_rst           synchronous active-high reset (count -> 0)
//   i_advance       step the counter on this edge
//   o_count         current count, registered
//   o_wrap          combinational: the coming edge takes the count from
//                   TOTAL-1 to 0 (i_advance and count at TOTAL-1)
//   o_sync_n        registered, active-low sync for o_count
//   o_next_visible  combinational: the count after the coming edge is in the
//                   visible region; the parent combines axes and registers it
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = DEF_H_VISIBLE,
   parameter int FRONT   = DEF_H_FRONT,
   parameter int SYNC    = DEF_H_SYNC,
   parameter int BACK    = DEF_H_BACK
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_advance,
   output coord_t o_count,
   output logic   o_wrap,
   output logic   o_sync_n,
   output logic   o_next_visible
);

   localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
   localparam int SYNC_START = VISIBLE + FRONT;
   localparam int SYNC_END   = SYNC_START + SYNC;

   localparam coord_t LAST_C       = coord_t'(TOTAL - 1);
   localparam coord_t VISIBLE_C    = coord_t'(VISIBLE);
   localparam coord_t SYNC_START_C = coord_t'(SYNC_START);
   localparam coord_t SYNC_END_C   = coord_t'(SYNC_END);

   // Sync level at count 0, used as the reset value.
   localparam logic RST_SYNC_N = (SYNC_START != 0);

   coord_t r_count;
   logic   r_sync_n;

   logic   w_at_last;
   logic   w_wrap;
   coord_t w_next;
   logic   w_next_sync_n;

   assign w_at_last = (r_count == LAST_C);
   assign w_wrap    = i_advance && w_at_last;

   always_comb begin
      w_next = r_count;
      if (i_advance) begin
         w_next = w_at_last ? '0 : r_count + coord_t'(1);
      end
   end

   // Sync is low for counts in [SYNC_START, SYNC_END).
   assign w_next_sync_n = !((w_next >= SYNC_START_C) && (w_next < SYNC_END_C));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count  <= '0;
         r_sync_n <= RST_SYNC_N;
      end else begin
         r_count  <= w_next;
         r_sync_n <= w_next_sync_n;
      end
   end

   assign o_count        = r_count;
   assign o_wrap         = w_wrap;
   assign o_sync_n       = r_sync_n;
   assign o_next_visible = (w_next < VISIBLE_C);

endmodule : vga_axis_counter

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for a 640x480 @ 60 Hz display on the 25 MHz
//   vga_clk. Produces scan coordinates, the visible-area qualifier and the
//   active-low syncs. Every output is a flop whose value is decoded from the
//   next-state counters, so coordinates and qualifiers presented in one cycle
//   always describe the same pixel.
//
// Ports:
//   vga_clk  pixel clock, single clock domain
//   reset    synchronous, active-high; forces position (0,0) and the decode
//            of (0,0): hs=1, vs=1, blank=1, frame_start=1, line_start=1
//   vga      vga_timing_gen_if.master: DrawX, DrawY, hs, vs, blank,
//            frame_start, line_start
//
// Structure:
//   Two vga_axis_counter instances. The horizontal one advances every cycle;
//   the vertical one advances on the horizontal wrap, so both counters reach
//   0 on the same edge at the end of a frame and vs only moves at DrawX=0.
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
) (
   input  logic              vga_clk,
   input  logic              reset,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL_P = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL_P = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Both counters are coord_t wide; refuse to build a timing they cannot count.
   if (!fits_coord(H_TOTAL_P)) begin : g_h_total_check
      $error("vga_timing_gen: horizontal total does not fit the coordinate width");
   end
   if (!fits_coord(V_TOTAL_P)) begin : g_v_total_check
      $error("vga_timing_gen: vertical total does not fit the coordinate width");
   end

   coord_t w_h_count;
   logic   w_h_wrap;
   logic   w_h_sync_n;
   logic   w_h_next_visible;

   coord_t w_v_count;
   logic   w_v_wrap;
   logic   w_v_sync_n;
   logic   w_v_next_visible;

   logic   r_blank;
   logic   r_frame_start;
   logic   r_line_start;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .i_clk          (vga_clk),
      .i_rst          (reset),
      .i_advance      (1'b1),
      .o_count        (w_h_count),
      .o_wrap         (w_h_wrap),
      .o_sync_n       (w_h_sync_n),
      .o_next_visible (w_h_next_visible)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .i_clk          (vga_clk),
      .i_rst          (reset),
      .i_advance      (w_h_wrap),
      .o_count        (w_v_count),
      .o_wrap         (w_v_wrap),
      .o_sync_n       (w_v_sync_n),
      .o_next_visible (w_v_next_visible)
   );

   // The horizontal counter advances every cycle, so its wrap means the next
   // DrawX is 0; a simultaneous vertical wrap means the next position is (0,0).
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_blank       <= 1'b1;
         r_frame_start <= 1'b1;
         r_line_start  <= 1'b1;
      end else begin
         r_blank       <= w_h_next_visible && w_v_next_visible;
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_h_wrap && w_v_wrap;
      end
   end

   assign vga.DrawX       = w_h_count;
   assign vga.DrawY       = w_v_count;
   assign vga.hs          = w_h_sync_n;
   assign vga.vs          = w_v_sync_n;
   assign vga.blank       = r_blank;
   assign vga.frame_start = r_frame_start;
   assign vga.line_start  = r_line_start;

endmodule : vga_timing_gen
